// File: rtl/key_feeder_if.sv
// Keyboard-side handshake plus recognizer-side outputs of key_feeder.
// master = keyboard/recognizer environment, slave = key_feeder.
interface key_feeder_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          key_valid;
  logic [6:0]    key_ascii;
  logic          key_ready;
  logic [6:0]    ascii;
  logic          step;
  logic          eol;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output key_valid, key_ascii,
    input  key_ready, ascii, step, eol, count, overflow
  );

  modport slave (
    input  key_valid, key_ascii,
    output key_ready, ascii, step, eol, count, overflow
  );
endinterface

// File: rtl/key_feeder.sv
// Buffers keyboard characters and replays them to the "123" recognizer as
// ascii + step pulses; CR/LF flush the recognizer history with NULs, then pulse eol.
module key_feeder #(
  parameter int DEPTH     = 4,
  parameter int CLEAR_LEN = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  key_feeder_if.slave  kif
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CLW = $clog2(CLEAR_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_CLR_HIGH,
    S_CLR_LOW,
    S_EOL
  } state_e;

  state_e         state_q;
  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [CLW-1:0] clr_q;
  logic [6:0]     ascii_q;
  logic           step_q, eol_q, ovf_q;

  logic       is_eol_key, is_ctrl, accept, push, pop;
  logic [7:0] entry_in, head;

  // Entry format is {marker, char}; end-of-line keys carry no character.
  assign is_eol_key = (kif.key_ascii == 7'h0A) || (kif.key_ascii == 7'h0D);
  assign is_ctrl    = (kif.key_ascii < 7'h20) || (kif.key_ascii == 7'h7F);
  assign entry_in   = is_eol_key ? 8'h80 : {1'b0, kif.key_ascii};

  // Ready is forced low while reset is held so nothing is accepted then.
  assign kif.key_ready = rst_n && (count_q < CW'(DEPTH));

  assign accept = kif.key_valid && kif.key_ready;
  assign push   = accept && (is_eol_key || !is_ctrl);
  assign pop    = (state_q == S_IDLE) && (count_q != '0);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ascii_q <= 7'h00;
      step_q  <= 1'b0;
      eol_q   <= 1'b0;
      clr_q   <= '0;
    end else begin
      step_q <= 1'b0;
      eol_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            step_q <= 1'b1;
            if (head[7]) begin
              ascii_q <= 7'h00;
              clr_q   <= CLW'(1);
              state_q <= S_CLR_HIGH;
            end else begin
              ascii_q <= head[6:0];
              state_q <= S_HIGH;
            end
          end
        end
        S_HIGH:     state_q <= S_IDLE;
        S_CLR_HIGH: state_q <= S_CLR_LOW;
        S_CLR_LOW: begin
          if (clr_q < CLW'(CLEAR_LEN)) begin
            clr_q   <= clr_q + 1'b1;
            step_q  <= 1'b1;
            state_q <= S_CLR_HIGH;
          end else begin
            eol_q   <= 1'b1;
            state_q <= S_EOL;
          end
        end
        S_EOL:      state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (kif.key_valid && !kif.key_ready) ovf_q <= 1'b1;
  end

  assign kif.ascii    = ascii_q;
  assign kif.step     = step_q;
  assign kif.eol      = eol_q;
  assign kif.count    = count_q;
  assign kif.overflow = ovf_q;

  a_step_eol_excl: assert property (@(posedge clk) disable iff (!rst_n) !(step_q && eol_q));
  a_count_bound:   assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
endmodule

// File: tb/tb_key_feeder.sv
// Randomized + directed scoreboard bench for key_feeder.
module tb_key_feeder;
  localparam int DEPTH     = 4;
  localparam int CLEAR_LEN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_feeder_if #(.DEPTH(DEPTH)) kif ();
  key_feeder #(.DEPTH(DEPTH), .CLEAR_LEN(CLEAR_LEN)) dut (.clk(clk), .rst_n(rst_n), .kif(kif));

  typedef struct {
    bit         is_eol;
    logic [6:0] a;
    int         gap;   // required cycles since previous output event, 0 = any
  } ev_t;

  ev_t        exp_q[$];
  int         step_cyc[$];
  int         eol_cyc[$];
  int         checks = 0, errors = 0, cyc = 0;
  int         last_ev = 0, nul_seen = 0, peak = 0;
  logic [6:0] hist [3];
  logic [6:0] prev_ascii = 7'h00;
  bit         exp_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit rec_match();
    return hist[0] == 7'h33 && hist[1] == 7'h32 && hist[2] == 7'h31;
  endfunction

  // Expected recognizer-side events for one accepted key.
  task automatic model_push(input logic [6:0] c);
    if (c == 7'h0A || c == 7'h0D) begin
      for (int i = 0; i < CLEAR_LEN; i++)
        exp_q.push_back('{is_eol: 1'b0, a: 7'h00, gap: (i == 0) ? 0 : 2});
      exp_q.push_back('{is_eol: 1'b1, a: 7'h00, gap: 2});
    end else if (!(c < 7'h20 || c == 7'h7F)) begin
      exp_q.push_back('{is_eol: 1'b0, a: c, gap: 0});
    end
  endtask

  initial begin : monitor
    ev_t ev;
    for (int i = 0; i < 3; i++) hist[i] = 7'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ascii = 7'h00;
      end else begin
        if (int'(kif.count) > peak) peak = int'(kif.count);
        if (!kif.step) chk("ascii_hold", kif.ascii, prev_ascii);
        if (kif.step || kif.eol) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: step=%0b eol=%0b ascii=%0h, expected none (cycle %0d)",
                     kif.step, kif.eol, kif.ascii, cyc);
          end else begin
            ev = exp_q.pop_front();
            chk("event_kind", kif.eol, ev.is_eol);
            if (!ev.is_eol) chk("ascii", kif.ascii, ev.a);
            if (ev.gap != 0) chk("event_gap", cyc - last_ev, ev.gap);
          end
          last_ev = cyc;
          if (kif.step) begin
            step_cyc.push_back(cyc);
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = kif.ascii;
            if (kif.ascii == 7'h00) nul_seen++;
          end
          if (kif.eol) eol_cyc.push_back(cyc);
        end
        prev_ascii = kif.ascii;
      end
    end
  end

  // One offered key for one edge; called at posedge+1.
  task automatic send(input logic [6:0] c, output bit acc, output int edge_no);
    kif.key_valid = 1'b1;
    kif.key_ascii = c;
    acc = kif.key_ready;
    if (acc) model_push(c);
    else exp_ovf = 1'b1;
    @(posedge clk); #1;
    edge_no = cyc;
    kif.key_valid = 1'b0;
    chk("overflow", kif.overflow, exp_ovf);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
    idle(3);
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    chk("count_idle", kif.count, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit acc;
    int e, c0, n0, ns, ne, refused, n, r;
    logic [6:0] ch;
    kif.key_valid = 1'b0;
    kif.key_ascii = 7'h00;

    #2;
    chk("rst_step", kif.step, 0);
    chk("rst_eol", kif.eol, 0);
    chk("rst_ascii", kif.ascii, 0);
    chk("rst_count", kif.count, 0);
    chk("rst_overflow", kif.overflow, 0);
    chk("rst_ready", kif.key_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    chk("ready_after_rst", kif.key_ready, 1);

    // '1','2','3' back to back
    peak = 0; step_cyc.delete();
    send(7'h31, acc, c0);
    send(7'h32, acc, e);
    send(7'h33, acc, e);
    drain();
    chk("t1_steps", step_cyc.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < step_cyc.size()) chk("t1_step_cycle", step_cyc[i] - c0, 1 + 2 * i);
    chk("t1_peak", peak, 2);
    chk("t1_match", rec_match(), 1);

    // '1','2','3',CR: match then cleared by flush
    ne = eol_cyc.size();
    send(7'h31, acc, e); send(7'h32, acc, e); send(7'h33, acc, e); send(7'h0D, acc, e);
    drain();
    chk("t2_match_cleared", rec_match(), 0);
    chk("t2_eols", eol_cyc.size() - ne, 1);

    // hold valid 8 edges into DEPTH 4
    refused = 0;
    for (int i = 0; i < 8; i++) begin
      send(7'h34 + 7'(i), acc, e);
      if (!acc) refused++;
    end
    chk("t3_refused", refused, 1);
    chk("t3_overflow", kif.overflow, 1);
    drain();
    chk("t3_overflow_sticky", kif.overflow, 1);

    // control chars swallowed
    ns = step_cyc.size();
    send(7'h09, acc, e); chk("t4_tab_acc", acc, 1);
    send(7'h7F, acc, e); chk("t4_del_acc", acc, 1);
    chk("t4_count_unchanged", kif.count, 0);
    send(7'h33, acc, e);
    drain();
    chk("t4_steps", step_cyc.size() - ns, 1);

    // CR then LF: two flushes
    ns = step_cyc.size(); ne = eol_cyc.size();
    send(7'h0D, acc, e); send(7'h0A, acc, e);
    drain();
    chk("t5_steps", step_cyc.size() - ns, 2 * CLEAR_LEN);
    chk("t5_eols", eol_cyc.size() - ne, 2);
    if (eol_cyc.size() >= 2)
      chk("t5_eol_spacing", (eol_cyc[eol_cyc.size()-1] - eol_cyc[eol_cyc.size()-2]) >= 7, 1);

    // reset during second NUL step
    n0 = nul_seen;
    send(7'h0D, acc, e);
    n = 0;
    while (nul_seen < n0 + 2 && n < 20) begin @(negedge clk); #1; n++; end
    chk("t6_reached_nul2", nul_seen - n0, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_step", kif.step, 0);
    chk("t6_eol", kif.eol, 0);
    chk("t6_ascii", kif.ascii, 0);
    chk("t6_count", kif.count, 0);
    chk("t6_overflow", kif.overflow, 0);
    exp_q.delete();
    exp_ovf = 1'b0;
    ne = eol_cyc.size();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send(7'h37, acc, e);
    chk("t6_accept", acc, 1);
    drain();
    chk("t6_no_eol", eol_cyc.size() - ne, 0);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: ch = 7'h31 + 7'(r);
        3:       ch = 7'h0D;
        4:       ch = 7'h0A;
        5:       ch = 7'($urandom_range(0, 31));
        6:       ch = 7'h7F;
        default: ch = 7'($urandom_range(32, 126));
      endcase
      send(ch, acc, e);
    end
    drain();
    chk("final_overflow", kif.overflow, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
